// File: rtl/endgame_controller.sv
// ----------------------------------------------------------------------------
// endgame_controller
// Sequences the match life-cycle IDLE -> PLAY -> SLIDE -> HOLD -> PLAY.
// Detects the winning score, gates the gameplay engine and drives the "END"
// banner renderer (position, visibility, blink). Paced by frame_tick.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-high
//   frame_tick   in   1   1-cycle pulse per VGA frame
//   btn_start    in   1   debounced start button (level)
//   score_p1     in   4   player-1 score
//   score_p2     in   4   player-2 score
//   game_run     out  1   gameplay engine enable
//   score_clear  out  1   1-cycle pulse clearing the score counters
//   end_x        out  10  banner start_x (constant END_X)
//   end_y        out  10  banner start_y
//   end_visible  out  1   banner pixels ORed into the pixel stream
//   winner       out  1   0 = player 1, 1 = player 2
//   state        out  2   IDLE=0, PLAY=1, SLIDE=2, HOLD=3
// ----------------------------------------------------------------------------
module endgame_controller #(
    parameter int unsigned WIN_SCORE       = 9,
    parameter int unsigned END_X           = 273,
    parameter int unsigned END_Y           = 200,
    parameter int unsigned SLIDE_STEP      = 8,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned MIN_HOLD_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic [3:0] score_p1,
    input  logic [3:0] score_p2,
    output logic       game_run,
    output logic       score_clear,
    output logic [9:0] end_x,
    output logic [9:0] end_y,
    output logic       end_visible,
    output logic       winner,
    output logic [1:0] state
);

    localparam int unsigned SW = 4;   // score width
    localparam int unsigned PW = 10;  // pixel coordinate width
    localparam int unsigned CW = 8;   // frame counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        SLIDE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          game_run_d, score_clear_d, end_visible_d, winner_d;
    logic [PW-1:0] end_y_d;
    logic [CW-1:0] hold_q, hold_d, blink_q, blink_d;
    logic          btn_q;
    logic          start_edge_c, win_c, win_check_c, slide_done_c;

    // Rising edge of the start button; a held button never retriggers.
    assign start_edge_c = btn_start & ~btn_q;

    assign win_c = (score_p1 >= SW'(WIN_SCORE)) | (score_p2 >= SW'(WIN_SCORE));

    // Scores still read the old match on the clk score_clear is high.
    assign win_check_c = win_c & ~score_clear;

    // Widened by one bit so a large step near the bottom cannot wrap.
    assign slide_done_c = ({1'b0, end_y} + (PW+1)'(SLIDE_STEP)) >= (PW+1)'(END_Y);

    assign state = state_q;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            game_run    <= 1'b0;
            score_clear <= 1'b0;
            end_x       <= PW'(END_X);
            end_y       <= '0;
            end_visible <= 1'b0;
            winner      <= 1'b0;
            hold_q      <= '0;
            blink_q     <= '0;
            btn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            game_run    <= game_run_d;
            score_clear <= score_clear_d;
            end_x       <= PW'(END_X);
            end_y       <= end_y_d;
            end_visible <= end_visible_d;
            winner      <= winner_d;
            hold_q      <= hold_d;
            blink_q     <= blink_d;
            btn_q       <= btn_start;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        game_run_d    = game_run;
        score_clear_d = 1'b0;
        end_y_d       = end_y;
        end_visible_d = end_visible;
        winner_d      = winner;
        hold_d        = hold_q;
        blink_d       = blink_q;

        case (state_q)
            IDLE: begin
                if (start_edge_c) begin
                    state_d       = PLAY;
                    game_run_d    = 1'b1;
                    score_clear_d = 1'b1;
                end
            end
            PLAY: begin
                if (win_check_c) begin
                    state_d       = SLIDE;
                    game_run_d    = 1'b0;
                    end_y_d       = '0;
                    end_visible_d = 1'b1;
                    // A tie goes to player 1.
                    winner_d      = (score_p1 < SW'(WIN_SCORE));
                end
            end
            SLIDE: begin
                if (frame_tick) begin
                    if (slide_done_c) begin
                        end_y_d = PW'(END_Y);
                        state_d = HOLD;
                        hold_d  = '0;
                        blink_d = '0;
                    end else begin
                        end_y_d = end_y + PW'(SLIDE_STEP);
                    end
                end
            end
            HOLD: begin
                // Restart has priority over a coincident frame_tick.
                if (start_edge_c && (hold_q == CW'(MIN_HOLD_FRAMES))) begin
                    state_d       = PLAY;
                    game_run_d    = 1'b1;
                    score_clear_d = 1'b1;
                    end_visible_d = 1'b0;
                    end_y_d       = '0;
                end else if (frame_tick) begin
                    if (hold_q != CW'(MIN_HOLD_FRAMES)) begin
                        hold_d = hold_q + CW'(1);
                    end
                    if (blink_q == CW'(BLINK_FRAMES - 1)) begin
                        blink_d       = '0;
                        end_visible_d = ~end_visible;
                    end else begin
                        blink_d = blink_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_endgame_controller.sv
// ----------------------------------------------------------------------------
// tb_endgame_controller
// Scoreboard bench. Stimulus pushes the hand-computed output bundle expected
// after each event; a monitor per DUT pops and compares whenever that DUT's
// output bundle changes. Instance dut uses the default parameters, dut7 uses
// SLIDE_STEP=7 to exercise the final clamp.
// ----------------------------------------------------------------------------
module tb_endgame_controller;

    typedef struct packed {
        logic [1:0] st;
        logic       run;
        logic       clr;
        logic [9:0] x;
        logic [9:0] y;
        logic       vis;
        logic       win;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, btn_start, tick7, btn7;
    logic [3:0] score_p1, score_p2, p1_7, zero4;

    logic       game_run, score_clear, end_visible, winner;
    logic [9:0] end_x, end_y;
    logic [1:0] state;
    logic       run7, clr7, vis7, win7;
    logic [9:0] x7, y7;
    logic [1:0] st7;

    int checks = 0;
    int errors = 0;

    obs_t  cur, cur7;
    obs_t  q[$];
    obs_t  q7[$];
    string qn[$];
    string q7n[$];

    always #5 clk = ~clk;

    endgame_controller dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start),
        .score_p1(score_p1), .score_p2(score_p2),
        .game_run(game_run), .score_clear(score_clear), .end_x(end_x), .end_y(end_y),
        .end_visible(end_visible), .winner(winner), .state(state)
    );

    endgame_controller #(.SLIDE_STEP(7)) dut7 (
        .clk(clk), .reset(reset), .frame_tick(tick7), .btn_start(btn7),
        .score_p1(p1_7), .score_p2(zero4),
        .game_run(run7), .score_clear(clr7), .end_x(x7), .end_y(y7),
        .end_visible(vis7), .winner(win7), .state(st7)
    );

    task automatic compare(input obs_t got, input obs_t exp, input string nm);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d run=%0b clr=%0b x=%0d y=%0d vis=%0b win=%0b, expected st=%0d run=%0b clr=%0b x=%0d y=%0d vis=%0b win=%0b",
                     nm, got.st, got.run, got.clr, got.x, got.y, got.vis, got.win,
                     exp.st, exp.run, exp.clr, exp.x, exp.y, exp.vis, exp.win);
        end
    endtask

    // Monitor for dut: any change of the output bundle consumes one expectation.
    obs_t got_m, prev_m;
    bit   first_m = 1'b1;
    always @(negedge clk) begin
        got_m = {state, game_run, score_clear, end_x, end_y, end_visible, winner};
        if (first_m || (got_m !== prev_m)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change: got st=%0d y=%0d vis=%0b clr=%0b, expected no change",
                         got_m.st, got_m.y, got_m.vis, got_m.clr);
            end else begin
                compare(got_m, q.pop_front(), qn.pop_front());
            end
        end
        prev_m  = got_m;
        first_m = 1'b0;
    end

    // Monitor for dut7.
    obs_t got_7, prev_7;
    bit   first_7 = 1'b1;
    always @(negedge clk) begin
        got_7 = {st7, run7, clr7, x7, y7, vis7, win7};
        if (first_7 || (got_7 !== prev_7)) begin
            if (q7.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change7: got st=%0d y=%0d, expected no change",
                         got_7.st, got_7.y);
            end else begin
                compare(got_7, q7.pop_front(), q7n.pop_front());
            end
        end
        prev_7  = got_7;
        first_7 = 1'b0;
    end

    task automatic push(input string nm);
        q.push_back(cur);
        qn.push_back(nm);
    endtask

    task automatic push7(input string nm);
        q7.push_back(cur7);
        q7n.push_back(nm);
    endtask

    // Scores reach the win condition; expect SLIDE entry next clk.
    task automatic win_start(input logic [3:0] a, input logic [3:0] b, input logic w,
                             input string nm);
        @(negedge clk);
        score_p1 = a;
        score_p2 = b;
        cur.st = 2'd2; cur.run = 1'b0; cur.y = 10'd0; cur.vis = 1'b1; cur.win = w;
        push(nm);
        repeat (2) @(negedge clk);
    endtask

    // n frame ticks in SLIDE: end_y = 8,16,...,192 then 200 / HOLD on tick 25.
    task automatic do_slide(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            if (k == 25) begin
                cur.y  = 10'd200;
                cur.st = 2'd3;
            end else begin
                cur.y = 10'(8 * k);
            end
            push("slide_tick");
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    // HOLD ticks; a 1-clk button pulse on tick ign_at (expected ignored) and on
    // tick restart_at (expected to restart). Blink toggles every 30th tick.
    task automatic hold_phase(input int ign_at, input int restart_at);
        for (int t = 1; t <= restart_at; t++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            btn_start  = (t == ign_at) || (t == restart_at);
            if (t == restart_at) begin
                cur.st = 2'd1; cur.run = 1'b1; cur.clr = 1'b1; cur.y = 10'd0; cur.vis = 1'b0;
                push("restart");
            end else if ((t % 30) == 0) begin
                cur.vis = ~cur.vis;
                push("blink_toggle");
            end
            @(negedge clk);
            frame_tick = 1'b0;
            btn_start  = 1'b0;
            if (t == restart_at) begin
                // Scores still at the win value here: must not re-detect.
                cur.clr = 1'b0;
                push("restart_clr_fall_no_rewin");
            end
            @(negedge clk);
            if (t == restart_at) begin
                score_p1 = 4'd0;
                score_p2 = 4'd0;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        btn_start  = 1'b0;
        score_p1   = 4'd0;
        score_p2   = 4'd0;
        tick7      = 1'b0;
        btn7       = 1'b0;
        p1_7       = 4'd0;
        zero4      = 4'd0;

        cur  = '0;
        cur.x = 10'd273;
        cur7 = cur;
        push("reset_state");
        push7("reset_state7");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Start from IDLE with the button held 50 clk: exactly one clear pulse.
        @(negedge clk);
        btn_start = 1'b1;
        cur.st = 2'd1; cur.run = 1'b1; cur.clr = 1'b1;
        push("idle_start");
        @(negedge clk);
        cur.clr = 1'b0;
        push("start_clr_fall");
        repeat (49) @(negedge clk);
        btn_start = 1'b0;

        // Player 1 steps 8 -> 9.
        @(negedge clk);
        score_p1 = 4'd8;
        repeat (3) @(negedge clk);
        win_start(4'd9, 4'd0, 1'b0, "win_p1");
        do_slide(25);
        hold_phase(100, 125);

        // Player 2 wins alone; restart at the first accepted tick.
        win_start(4'd0, 4'd9, 1'b1, "win_p2");
        do_slide(25);
        hold_phase(120, 121);

        // Tie goes to player 1; then reset mid-SLIDE at end_y=96.
        win_start(4'd9, 4'd9, 1'b0, "win_tie");
        do_slide(12);
        @(posedge clk);
        #2;
        cur = '0;
        cur.x = 10'd273;
        push("reset_mid_slide");
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        score_p1 = 4'd0;
        score_p2 = 4'd0;

        // SLIDE_STEP=7: 7..196 over 28 ticks, clamp to 200 on the 29th.
        @(negedge clk);
        btn7 = 1'b1;
        cur7.st = 2'd1; cur7.run = 1'b1; cur7.clr = 1'b1;
        push7("start7");
        @(negedge clk);
        cur7.clr = 1'b0;
        push7("start7_clr_fall");
        @(negedge clk);
        btn7 = 1'b0;
        p1_7 = 4'd9;
        cur7.st = 2'd2; cur7.run = 1'b0; cur7.vis = 1'b1;
        push7("win7");
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            tick7 = 1'b1;
            if (k == 29) begin
                cur7.y  = 10'd200;
                cur7.st = 2'd3;
            end else begin
                cur7.y = 10'(7 * k);
            end
            push7("slide7_tick");
            @(negedge clk);
            tick7 = 1'b0;
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d unconsumed, expected 0", q.size());
        end
        checks++;
        if (q7.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations7: got %0d unconsumed, expected 0", q7.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
